// File: rtl/uart_pkg.sv
// Shared types for the UART packet parser.
// Contents: parser state enum, error code enum, default start-of-frame byte.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_BAD_LEN  = 3'd1,
    ERR_BAD_CSUM = 3'd2,
    ERR_OVERRUN  = 3'd3,
    ERR_TIMEOUT  = 3'd4
  } err_code_e;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: DEPTH x 8 register array, one synchronous write port and
// one combinational read port.
// Ports: clk_i; wr_en_i/wr_addr_i/wr_data_i write port; rd_addr_i -> rd_data_c.
module uart_pkt_buf
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_c
);

  logic [7:0] mem_q [DEPTH];

  // Storage only; contents are meaningless until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_c = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_pkt_parser.sv
// Frames uart_rx bytes into packets (SOF, LEN, payload, XOR checksum),
// buffers packets that pass the checksum and replays the payload on a
// valid/ready byte stream. Bad packets are dropped and flagged.
// Ports: clk_i, rst_i (sync, active-high); rx_byte_i/rx_done_tick_i from
// uart_rx; m_data_o/m_valid_o/m_ready_i/m_last_o payload stream;
// pkt_ok_tick_o, pkt_err_tick_o, err_code_o status; busy_o (not IDLE).
// Optional: define UART_PKT_TIMEOUT_EN to abort a stalled partial packet
// after TIMEOUT_CYCLES cycles without a byte.
module uart_rx_pkt_parser
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_byte_i,
  input  logic       rx_done_tick_i,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic       m_last_o,
  output logic       pkt_ok_tick_o,
  output logic       pkt_err_tick_o,
  output logic [2:0] err_code_o,
  output logic       busy_o
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = $clog2(MAX_LEN);

  state_e    state_q, state_d;
  err_code_e err_code_q, err_code_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic          pkt_ok_q, pkt_ok_d;
  logic          pkt_err_q, pkt_err_d;
  logic          busy_q, busy_d;

  logic          wr_en_c;
  logic [AW-1:0] rd_addr_c;
  logic [7:0]    rd_data_c;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES);
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES == 0);
`endif

  uart_pkt_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en_c),
    .wr_addr_i (AW'(wr_ptr_q)),
    .wr_data_i (rx_byte_i),
    .rd_addr_i (rd_addr_c),
    .rd_data_c (rd_data_c)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    len_d      = len_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    csum_d     = csum_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    pkt_ok_d   = 1'b0;
    pkt_err_d  = 1'b0;
    wr_en_c    = 1'b0;
    rd_addr_c  = AW'(rd_ptr_q);
`ifdef UART_PKT_TIMEOUT_EN
    to_cnt_d   = '0;
`endif

    unique case (state_q)
      IDLE: begin
        if (rx_done_tick_i && (rx_byte_i == SOF_BYTE)) begin
          state_d = LEN;
        end
      end
      LEN: begin
        if (rx_done_tick_i) begin
          if ((rx_byte_i == 8'd0) || (rx_byte_i > 8'(MAX_LEN))) begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_BAD_LEN;
            state_d    = IDLE;
          end else begin
            len_d    = LW'(rx_byte_i);
            csum_d   = rx_byte_i;
            wr_ptr_d = '0;
            state_d  = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (rx_done_tick_i) begin
          wr_en_c  = 1'b1;
          csum_d   = csum_q ^ rx_byte_i;
          wr_ptr_d = wr_ptr_q + LW'(1);
          if (wr_ptr_q == (len_q - LW'(1))) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (rx_done_tick_i) begin
          if (rx_byte_i == csum_q) begin
            // Preload the first payload byte so valid and data rise together.
            rd_addr_c = '0;
            rd_ptr_d  = '0;
            m_data_d  = rd_data_c;
            m_last_d  = (len_q == LW'(1));
            m_valid_d = 1'b1;
            pkt_ok_d  = 1'b1;
            state_d   = DRAIN;
          end else begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_BAD_CSUM;
            state_d    = IDLE;
          end
        end
      end
      DRAIN: begin
        // Any byte arriving here is dropped, SOF included.
        if (rx_done_tick_i) begin
          pkt_err_d  = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
        if (m_valid_q && m_ready_i) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = IDLE;
          end else begin
            rd_ptr_d  = rd_ptr_q + LW'(1);
            rd_addr_c = AW'(rd_ptr_q + LW'(1));
            m_data_d  = rd_data_c;
            m_last_d  = ((rd_ptr_q + LW'(1)) == (len_q - LW'(1)));
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_PKT_TIMEOUT_EN
    // Inter-byte watchdog while a packet is being received; a tick restarts it.
    if (((state_q == LEN) || (state_q == PAYLOAD) || (state_q == CSUM)) && !rx_done_tick_i) begin
      if (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
        pkt_err_d  = 1'b1;
        err_code_d = ERR_TIMEOUT;
        state_d    = IDLE;
      end else begin
        to_cnt_d = to_cnt_q + TCW'(1);
      end
    end
`endif

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      err_code_q <= ERR_NONE;
      len_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      csum_q     <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      pkt_ok_q   <= 1'b0;
      pkt_err_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_PKT_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      len_q      <= len_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      csum_q     <= csum_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      pkt_ok_q   <= pkt_ok_d;
      pkt_err_q  <= pkt_err_d;
      busy_q     <= busy_d;
`ifdef UART_PKT_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  assign m_data_o       = m_data_q;
  assign m_valid_o      = m_valid_q;
  assign m_last_o       = m_last_q;
  assign pkt_ok_tick_o  = pkt_ok_q;
  assign pkt_err_tick_o = pkt_err_q;
  assign err_code_o     = err_code_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_uart_rx_pkt_parser.sv
// Directed bench for uart_rx_pkt_parser (MAX_LEN=16, TIMEOUT_CYCLES=50).
// Each table row is one clock: inputs applied before the edge, outputs
// checked 1 time unit after it.
module tb_uart_rx_pkt_parser;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] rx_byte_i;
  logic       rx_done_tick_i;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic       m_last_o;
  logic       pkt_ok_tick_o;
  logic       pkt_err_tick_o;
  logic [2:0] err_code_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  uart_rx_pkt_parser #(
    .MAX_LEN        (16),
    .SOF_BYTE       (8'hA5),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rx_byte_i      (rx_byte_i),
    .rx_done_tick_i (rx_done_tick_i),
    .m_data_o       (m_data_o),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i),
    .m_last_o       (m_last_o),
    .pkt_ok_tick_o  (pkt_ok_tick_o),
    .pkt_err_tick_o (pkt_err_tick_o),
    .err_code_o     (err_code_o),
    .busy_o         (busy_o)
  );

  typedef struct {
    logic       tk;
    logic [7:0] b;
    logic       rdy;
    logic       vl;
    logic [7:0] d;
    logic       ls;
    logic       ok;
    logic       er;
    logic [2:0] cd;
    logic       by;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic tk, input logic [7:0] b, input logic rdy,
                            input logic vl, input logic [7:0] d, input logic ls,
                            input logic ok, input logic er, input logic [2:0] cd,
                            input logic by);
    vec_t t;
    t.tk = tk; t.b = b; t.rdy = rdy; t.vl = vl; t.d = d; t.ls = ls;
    t.ok = ok; t.er = er; t.cd = cd; t.by = by;
    vecs.push_back(t);
  endfunction

  // One clock with the given inputs; returns 1 unit after the edge.
  task automatic cyc(input logic tk, input logic [7:0] b, input logic rdy);
    rx_done_tick_i = tk;
    rx_byte_i      = b;
    m_ready_i      = rdy;
    @(posedge clk_i);
    #1;
  endtask

  // Data and last are only meaningful while valid is high.
  task automatic chk(input string nm, input logic vl, input logic [7:0] d, input logic ls,
                     input logic ok, input logic er, input logic [2:0] cd, input logic by);
    logic [15:0] act;
    logic [15:0] exp;
    act = {m_valid_o, m_valid_o ? m_data_o : 8'h00, m_valid_o & m_last_o,
           pkt_ok_tick_o, pkt_err_tick_o, err_code_o, busy_o};
    exp = {vl, vl ? d : 8'h00, vl & ls, ok, er, cd, by};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got vld=%b data=%h last=%b ok=%b err=%b code=%0d busy=%b, expected vld=%b data=%h last=%b ok=%b err=%b code=%0d busy=%b",
               nm, act[15], act[14:7], act[6], act[5], act[4], act[3:1], act[0],
               exp[15], exp[14:7], exp[6], exp[5], exp[4], exp[3:1], exp[0]);
    end
  endtask

  initial begin
    logic [7:0] cs;
    logic       seen_err;

    // Good packet 11,22,33
    v(1,8'hA5,1, 0,8'h00,0, 0,0,3'd0,1);
    v(1,8'h03,1, 0,8'h00,0, 0,0,3'd0,1);
    v(1,8'h11,1, 0,8'h00,0, 0,0,3'd0,1);
    v(1,8'h22,1, 0,8'h00,0, 0,0,3'd0,1);
    v(1,8'h33,1, 0,8'h00,0, 0,0,3'd0,1);
    v(1,8'h03,1, 1,8'h11,0, 1,0,3'd0,1);
    v(0,8'h00,1, 1,8'h22,0, 0,0,3'd0,1);
    v(0,8'h00,1, 1,8'h33,1, 0,0,3'd0,1);
    v(0,8'h00,1, 0,8'h00,0, 0,0,3'd0,0);
    // Bad checksum, then a one-byte good packet
    v(1,8'hA5,1, 0,8'h00,0, 0,0,3'd0,1);
    v(1,8'h03,1, 0,8'h00,0, 0,0,3'd0,1);
    v(1,8'h11,1, 0,8'h00,0, 0,0,3'd0,1);
    v(1,8'h22,1, 0,8'h00,0, 0,0,3'd0,1);
    v(1,8'h33,1, 0,8'h00,0, 0,0,3'd0,1);
    v(1,8'h04,1, 0,8'h00,0, 0,1,3'd2,0);
    v(0,8'h00,1, 0,8'h00,0, 0,0,3'd2,0);
    v(1,8'hA5,1, 0,8'h00,0, 0,0,3'd2,1);
    v(1,8'h01,1, 0,8'h00,0, 0,0,3'd2,1);
    v(1,8'h5A,1, 0,8'h00,0, 0,0,3'd2,1);
    v(1,8'h5B,1, 1,8'h5A,1, 1,0,3'd2,1);
    v(0,8'h00,1, 0,8'h00,0, 0,0,3'd2,0);
    // Noise, zero length, oversize length
    v(1,8'h00,1, 0,8'h00,0, 0,0,3'd2,0);
    v(1,8'hFF,1, 0,8'h00,0, 0,0,3'd2,0);
    v(1,8'hA5,1, 0,8'h00,0, 0,0,3'd2,1);
    v(1,8'h00,1, 0,8'h00,0, 0,1,3'd1,0);
    v(0,8'h00,1, 0,8'h00,0, 0,0,3'd1,0);
    v(1,8'hA5,1, 0,8'h00,0, 0,0,3'd1,1);
    v(1,8'h11,1, 0,8'h00,0, 0,1,3'd1,0);
    // Backpressure with an overrun during drain
    v(1,8'hA5,0, 0,8'h00,0, 0,0,3'd1,1);
    v(1,8'h02,0, 0,8'h00,0, 0,0,3'd1,1);
    v(1,8'hAA,0, 0,8'h00,0, 0,0,3'd1,1);
    v(1,8'hBB,0, 0,8'h00,0, 0,0,3'd1,1);
    v(1,8'h13,0, 1,8'hAA,0, 1,0,3'd1,1);
    v(0,8'h00,0, 1,8'hAA,0, 0,0,3'd1,1);
    v(1,8'hA5,0, 1,8'hAA,0, 0,1,3'd3,1);
    v(0,8'h00,0, 1,8'hAA,0, 0,0,3'd3,1);
    v(0,8'h00,1, 1,8'hBB,1, 0,0,3'd3,1);
    v(0,8'h00,1, 0,8'h00,0, 0,0,3'd3,0);
    // Tick coinciding with the final handshake is an overrun; next byte parses
    v(1,8'hA5,1, 0,8'h00,0, 0,0,3'd3,1);
    v(1,8'h01,1, 0,8'h00,0, 0,0,3'd3,1);
    v(1,8'h77,1, 0,8'h00,0, 0,0,3'd3,1);
    v(1,8'h76,1, 1,8'h77,1, 1,0,3'd3,1);
    v(1,8'hA5,1, 0,8'h00,0, 0,1,3'd3,0);
    v(1,8'hA5,1, 0,8'h00,0, 0,0,3'd3,1);
    v(1,8'h00,1, 0,8'h00,0, 0,1,3'd1,0);

    rst_i = 1'b1; rx_done_tick_i = 1'b0; rx_byte_i = 8'h00; m_ready_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("reset", 0,8'h00,0, 0,0,3'd0,0);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].tk, vecs[i].b, vecs[i].rdy);
      chk($sformatf("vec%0d", i), vecs[i].vl, vecs[i].d, vecs[i].ls,
          vecs[i].ok, vecs[i].er, vecs[i].cd, vecs[i].by);
    end

    // Maximum-length packet fills the whole buffer
    cyc(1, 8'hA5, 1);
    cyc(1, 8'h10, 1);
    cs = 8'h10;
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i + 1), 1);
      cs = cs ^ 8'(i + 1);
    end
    cyc(1, cs, 1);
    chk("maxlen_ok", 1,8'h01,0, 1,0,3'd1,1);
    for (int k = 1; k < 16; k++) begin
      cyc(0, 8'h00, 1);
      chk($sformatf("maxlen_b%0d", k), 1, 8'(k + 1), (k == 15), 0,0,3'd1,1);
    end
    cyc(0, 8'h00, 1);
    chk("maxlen_end", 0,8'h00,0, 0,0,3'd1,0);

    // Reset mid-packet
    cyc(1, 8'hA5, 1);
    cyc(1, 8'h03, 1);
    cyc(1, 8'h11, 1);
    rst_i = 1'b1;
    cyc(0, 8'h00, 1);
    chk("midrst", 0,8'h00,0, 0,0,3'd0,0);
    rst_i = 1'b0;
    cyc(0, 8'h00, 1);
    chk("midrst_post", 0,8'h00,0, 0,0,3'd0,0);
    cyc(1, 8'hA5, 1);
    cyc(1, 8'h01, 1);
    cyc(1, 8'h42, 1);
    cyc(1, 8'h43, 1);
    chk("midrst_pkt", 1,8'h42,1, 1,0,3'd0,1);
    cyc(0, 8'h00, 1);
    chk("midrst_done", 0,8'h00,0, 0,0,3'd0,0);

    // Stall after LEN
    cyc(1, 8'hA5, 1);
    cyc(1, 8'h03, 1);
    seen_err = 1'b0;
    for (int i = 0; i < 49; i++) begin
      cyc(0, 8'h00, 1);
      seen_err = seen_err | pkt_err_tick_o;
    end
    total++;
    if (seen_err !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL stall_49: got err_seen=%b busy=%b, expected err_seen=0 busy=1", seen_err, busy_o);
    end
    cyc(0, 8'h00, 1);
`ifdef UART_PKT_TIMEOUT_EN
    chk("timeout", 0,8'h00,0, 0,1,3'd4,0);
    cyc(0, 8'h00, 1);
    chk("timeout_idle", 0,8'h00,0, 0,0,3'd4,0);
`else
    chk("stall_50", 0,8'h00,0, 0,0,3'd0,1);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 8'h00, 1);
      seen_err = seen_err | pkt_err_tick_o;
    end
    chk("stall_70", 0,8'h00,0, 0,seen_err,3'd0,1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
